// File: rtl/msg_to_pkt_queue_if.sv
// Bus-side chunk handshake and packet output port of the message-to-packet queue.
// The master side is the chunk source / output port; the slave side is the queue itself.
interface msg_to_pkt_queue_if #(
  parameter int FLIT_WIDTH        = 32,
  parameter int MAX_PACKET_LENGHT = 5,
  parameter int N_BITS_LEN        = 3
);
  logic [FLIT_WIDTH-1:0]                   header_i;
  logic [FLIT_WIDTH-1:0]                   data_i;
  logic                                    chunk_valid_i;
  logic                                    head_only_i;
  logic                                    last_i;
  logic                                    abort_i;
  logic                                    ready_o;
  logic                                    overflow_o;
  logic                                    r_msg_to_pkt_o;
  logic                                    g_msg_to_pkt_i;
  logic [MAX_PACKET_LENGHT*FLIT_WIDTH-1:0] out_link_o;
  logic [N_BITS_LEN-1:0]                   out_len_o;

  modport master (
    output header_i, data_i, chunk_valid_i, head_only_i, last_i, abort_i, g_msg_to_pkt_i,
    input  ready_o, overflow_o, r_msg_to_pkt_o, out_link_o, out_len_o
  );

  modport slave (
    input  header_i, data_i, chunk_valid_i, head_only_i, last_i, abort_i, g_msg_to_pkt_i,
    output ready_o, overflow_o, r_msg_to_pkt_o, out_link_o, out_len_o
  );
endinterface

// File: rtl/msg_to_pkt_queue.sv
// Assembles bus message chunks into NoC packets (head flit + up to MAX_PACKET_LENGHT-1 data flits)
// and queues whole packets for the output port, which takes them one at a time via request/grant.
module msg_to_pkt_queue #(
  parameter int QUEUE_DEPTH       = 4,
  parameter int N_BITS_POINTER    = 2,
  parameter int FLIT_WIDTH        = 32,
  parameter int MAX_PACKET_LENGHT = 5,
  parameter int N_BITS_LEN        = 3
) (
  input logic              clk,
  input logic              rst,
  msg_to_pkt_queue_if.slave bus
);

  typedef logic [FLIT_WIDTH-1:0] flit_t;

  localparam logic [N_BITS_POINTER-1:0] LAST_PTR  = N_BITS_POINTER'(QUEUE_DEPTH - 1);
  localparam logic [N_BITS_LEN-1:0]     LAST_FLIT = N_BITS_LEN'(MAX_PACKET_LENGHT - 1);

  flit_t                   slot_q [QUEUE_DEPTH][MAX_PACKET_LENGHT];
  logic [N_BITS_LEN-1:0]   len_q  [QUEUE_DEPTH];

  logic [QUEUE_DEPTH-1:0]    valid_q, valid_d;
  logic [N_BITS_POINTER-1:0] head_q, head_d;
  logic [N_BITS_POINTER-1:0] tail_q, tail_d;
  logic [N_BITS_LEN-1:0]     cnt_q, cnt_d;
  logic                      overflow_q, overflow_d;

  logic                      ready_s, req_s, accept_s, grant_s;
  logic                      open_s, append_s, close_s;
  logic [N_BITS_LEN-1:0]     wr_idx_s, wr_len_s;
  logic [N_BITS_POINTER-1:0] tail_nxt_s, head_nxt_s;
  logic [MAX_PACKET_LENGHT*FLIT_WIDTH-1:0] link_s;

  assign ready_s    = ~valid_q[tail_q];
  assign req_s      = valid_q[head_q];
  assign accept_s   = bus.chunk_valid_i & ready_s & ~bus.abort_i;
  assign grant_s    = bus.g_msg_to_pkt_i & req_s;
  assign tail_nxt_s = (tail_q == LAST_PTR) ? {N_BITS_POINTER{1'b0}} : tail_q + N_BITS_POINTER'(1);
  assign head_nxt_s = (head_q == LAST_PTR) ? {N_BITS_POINTER{1'b0}} : head_q + N_BITS_POINTER'(1);
  assign wr_idx_s   = cnt_q + N_BITS_LEN'(1);

  // Assembly decisions and next state of pointers, valid bits and flit count.
  always_comb begin
    valid_d    = valid_q;
    head_d     = head_q;
    tail_d     = tail_q;
    cnt_d      = cnt_q;
    overflow_d = 1'b0;
    open_s     = 1'b0;
    append_s   = 1'b0;
    close_s    = 1'b0;
    wr_len_s   = cnt_q + N_BITS_LEN'(2);

    if (bus.abort_i) begin
      cnt_d = {N_BITS_LEN{1'b0}};
    end else if (accept_s) begin
      if (bus.head_only_i) begin
        // A header-only chunk also discards any partial message at the tail.
        open_s   = 1'b1;
        close_s  = 1'b1;
        wr_len_s = N_BITS_LEN'(1);
      end else if (cnt_q == {N_BITS_LEN{1'b0}}) begin
        open_s = 1'b1;
        cnt_d  = N_BITS_LEN'(1);
        if (bus.last_i) begin
          close_s = 1'b1;
        end else begin
          close_s = 1'b0;
        end
      end else begin
        append_s = 1'b1;
        cnt_d    = wr_idx_s;
        if (bus.last_i) begin
          close_s = 1'b1;
        end else if (wr_idx_s == LAST_FLIT) begin
          close_s    = 1'b1;
          overflow_d = 1'b1;
        end else begin
          close_s = 1'b0;
        end
      end
    end else begin
      cnt_d = cnt_q;
    end

    if (close_s) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_nxt_s;
      cnt_d           = {N_BITS_LEN{1'b0}};
    end else begin
      tail_d = tail_q;
    end

    if (grant_s) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_nxt_s;
    end else begin
      head_d = head_q;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= {QUEUE_DEPTH{1'b0}};
      head_q     <= {N_BITS_POINTER{1'b0}};
      tail_q     <= {N_BITS_POINTER{1'b0}};
      cnt_q      <= {N_BITS_LEN{1'b0}};
      overflow_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
    end
  end

  // Slot storage is qualified by the valid bits, so it carries no reset.
  always_ff @(posedge clk) begin
    if (open_s) begin
      for (int f = 0; f < MAX_PACKET_LENGHT; f++) begin
        if (f == 0) begin
          slot_q[tail_q][f] <= bus.header_i;
        end else if ((f == 1) && !bus.head_only_i) begin
          slot_q[tail_q][f] <= bus.data_i;
        end else begin
          slot_q[tail_q][f] <= {FLIT_WIDTH{1'b0}};
        end
      end
    end else if (append_s) begin
      slot_q[tail_q][wr_idx_s] <= bus.data_i;
    end
    if (close_s) begin
      len_q[tail_q] <= wr_len_s;
    end
  end

  // Flatten the head slot onto the output link, flit 0 in the LSBs.
  always_comb begin
    link_s = {(MAX_PACKET_LENGHT*FLIT_WIDTH){1'b0}};
    for (int f = 0; f < MAX_PACKET_LENGHT; f++) begin
      link_s[f*FLIT_WIDTH +: FLIT_WIDTH] = slot_q[head_q][f];
    end
  end

  assign bus.ready_o        = ready_s;
  assign bus.r_msg_to_pkt_o = req_s;
  assign bus.overflow_o     = overflow_q;
  assign bus.out_link_o     = link_s;
  assign bus.out_len_o      = len_q[head_q];

endmodule

// File: tb/tb_msg_to_pkt_queue.sv
// Directed table-driven bench for msg_to_pkt_queue plus hand-written reset sequences.
module tb_msg_to_pkt_queue;

  logic clk = 1'b0;
  logic rst = 1'b1;

  msg_to_pkt_queue_if #(.FLIT_WIDTH(32), .MAX_PACKET_LENGHT(5), .N_BITS_LEN(3)) bus_if ();

  msg_to_pkt_queue #(
    .QUEUE_DEPTH(4), .N_BITS_POINTER(2), .FLIT_WIDTH(32), .MAX_PACKET_LENGHT(5), .N_BITS_LEN(3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         cv, ho, last, ab, g;
    logic [31:0]  hdr, dat;
    logic         e_rdy, e_req, e_ovf;
    logic [2:0]   e_len;
    logic [159:0] e_link;
  } vec_t;

  vec_t vq[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic logic [159:0] mk(input logic [31:0] f0, f1, f2, f3, f4);
    return {f4, f3, f2, f1, f0};
  endfunction

  task automatic add(input logic cv, ho, last, ab, g, input logic [31:0] hdr, dat,
                     input logic rdy, req, ovf, input logic [2:0] len, input logic [159:0] link);
    vec_t v;
    v.cv = cv; v.ho = ho; v.last = last; v.ab = ab; v.g = g;
    v.hdr = hdr; v.dat = dat;
    v.e_rdy = rdy; v.e_req = req; v.e_ovf = ovf; v.e_len = len; v.e_link = link;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic cv, ho, last, ab, g, input logic [31:0] hdr, dat);
    bus_if.chunk_valid_i  = cv;
    bus_if.head_only_i    = ho;
    bus_if.last_i         = last;
    bus_if.abort_i        = ab;
    bus_if.g_msg_to_pkt_i = g;
    bus_if.header_i       = hdr;
    bus_if.data_i         = dat;
  endtask

  initial begin
    logic [159:0] z;
    logic [31:0]  h0;
    z  = 160'h0;
    h0 = 32'hC0DE_00F0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // cv ho last ab g | hdr dat | ready req ovf len link
    add(1'b1,1'b0,1'b0,1'b0,1'b0, h0, 32'hA1,          1'b1,1'b0,1'b0,3'd0, z);
    add(1'b1,1'b0,1'b0,1'b0,1'b0, 32'hBAD, 32'hA2,     1'b1,1'b0,1'b0,3'd0, z);
    add(1'b1,1'b0,1'b1,1'b0,1'b0, 32'hBAD, 32'hA3,     1'b1,1'b1,1'b0,3'd4, mk(h0,32'hA1,32'hA2,32'hA3,32'h0));
    add(1'b0,1'b0,1'b0,1'b0,1'b1, 32'h0, 32'h0,        1'b1,1'b0,1'b0,3'd0, z);
    add(1'b1,1'b1,1'b0,1'b0,1'b0, 32'h55, 32'hDEAD,    1'b1,1'b1,1'b0,3'd1, mk(32'h55,32'h0,32'h0,32'h0,32'h0));
    add(1'b0,1'b0,1'b0,1'b0,1'b1, 32'h0, 32'h0,        1'b1,1'b0,1'b0,3'd0, z);
    // five chunks without last: force-close after the fourth data flit
    add(1'b1,1'b0,1'b0,1'b0,1'b0, 32'h100, 32'h11,     1'b1,1'b0,1'b0,3'd0, z);
    add(1'b1,1'b0,1'b0,1'b0,1'b0, 32'h100, 32'h12,     1'b1,1'b0,1'b0,3'd0, z);
    add(1'b1,1'b0,1'b0,1'b0,1'b0, 32'h100, 32'h13,     1'b1,1'b0,1'b0,3'd0, z);
    add(1'b1,1'b0,1'b0,1'b0,1'b0, 32'h100, 32'h14,     1'b1,1'b1,1'b1,3'd5, mk(32'h100,32'h11,32'h12,32'h13,32'h14));
    add(1'b1,1'b0,1'b0,1'b0,1'b0, 32'h200, 32'h15,     1'b1,1'b1,1'b0,3'd5, mk(32'h100,32'h11,32'h12,32'h13,32'h14));
    add(1'b1,1'b0,1'b1,1'b0,1'b1, 32'hBAD, 32'h16,     1'b1,1'b1,1'b0,3'd3, mk(32'h200,32'h15,32'h16,32'h0,32'h0));
    add(1'b0,1'b0,1'b0,1'b0,1'b1, 32'h0, 32'h0,        1'b1,1'b0,1'b0,3'd0, z);
    // abort wins over a same-cycle last chunk
    add(1'b1,1'b0,1'b0,1'b0,1'b0, 32'h300, 32'h31,     1'b1,1'b0,1'b0,3'd0, z);
    add(1'b1,1'b0,1'b0,1'b0,1'b0, 32'h300, 32'h32,     1'b1,1'b0,1'b0,3'd0, z);
    add(1'b1,1'b0,1'b1,1'b1,1'b0, 32'h300, 32'h33,     1'b1,1'b0,1'b0,3'd0, z);
    add(1'b1,1'b0,1'b1,1'b0,1'b0, 32'h400, 32'h41,     1'b1,1'b1,1'b0,3'd2, mk(32'h400,32'h41,32'h0,32'h0,32'h0));
    add(1'b0,1'b0,1'b0,1'b0,1'b1, 32'h0, 32'h0,        1'b1,1'b0,1'b0,3'd0, z);
    // header-only chunk replaces a partial message
    add(1'b1,1'b0,1'b0,1'b0,1'b0, 32'h500, 32'h51,     1'b1,1'b0,1'b0,3'd0, z);
    add(1'b1,1'b1,1'b0,1'b0,1'b0, 32'h56, 32'h57,      1'b1,1'b1,1'b0,3'd1, mk(32'h56,32'h0,32'h0,32'h0,32'h0));
    add(1'b0,1'b0,1'b0,1'b0,1'b1, 32'h0, 32'h0,        1'b1,1'b0,1'b0,3'd0, z);
    // fill all four slots, drop an extra chunk, then wrap with grants
    add(1'b1,1'b1,1'b0,1'b0,1'b0, 32'h41, 32'h0,       1'b1,1'b1,1'b0,3'd1, mk(32'h41,32'h0,32'h0,32'h0,32'h0));
    add(1'b1,1'b1,1'b0,1'b0,1'b0, 32'h42, 32'h0,       1'b1,1'b1,1'b0,3'd1, mk(32'h41,32'h0,32'h0,32'h0,32'h0));
    add(1'b1,1'b1,1'b0,1'b0,1'b0, 32'h43, 32'h0,       1'b1,1'b1,1'b0,3'd1, mk(32'h41,32'h0,32'h0,32'h0,32'h0));
    add(1'b1,1'b1,1'b0,1'b0,1'b0, 32'h44, 32'h0,       1'b0,1'b1,1'b0,3'd1, mk(32'h41,32'h0,32'h0,32'h0,32'h0));
    add(1'b1,1'b1,1'b0,1'b0,1'b0, 32'h99, 32'h0,       1'b0,1'b1,1'b0,3'd1, mk(32'h41,32'h0,32'h0,32'h0,32'h0));
    add(1'b0,1'b0,1'b0,1'b0,1'b1, 32'h0, 32'h0,        1'b1,1'b1,1'b0,3'd1, mk(32'h42,32'h0,32'h0,32'h0,32'h0));
    add(1'b1,1'b1,1'b0,1'b0,1'b0, 32'h50, 32'h0,       1'b0,1'b1,1'b0,3'd1, mk(32'h42,32'h0,32'h0,32'h0,32'h0));
    add(1'b0,1'b0,1'b0,1'b0,1'b1, 32'h0, 32'h0,        1'b1,1'b1,1'b0,3'd1, mk(32'h43,32'h0,32'h0,32'h0,32'h0));
    add(1'b1,1'b1,1'b0,1'b0,1'b1, 32'h51, 32'h0,       1'b1,1'b1,1'b0,3'd1, mk(32'h44,32'h0,32'h0,32'h0,32'h0));
    add(1'b1,1'b1,1'b0,1'b0,1'b1, 32'h52, 32'h0,       1'b1,1'b1,1'b0,3'd1, mk(32'h50,32'h0,32'h0,32'h0,32'h0));
    add(1'b1,1'b1,1'b0,1'b0,1'b1, 32'h53, 32'h0,       1'b1,1'b1,1'b0,3'd1, mk(32'h51,32'h0,32'h0,32'h0,32'h0));
    add(1'b1,1'b0,1'b1,1'b0,1'b1, 32'h54, 32'hE4,      1'b1,1'b1,1'b0,3'd1, mk(32'h52,32'h0,32'h0,32'h0,32'h0));
    add(1'b1,1'b1,1'b0,1'b0,1'b1, 32'h55, 32'h0,       1'b1,1'b1,1'b0,3'd1, mk(32'h53,32'h0,32'h0,32'h0,32'h0));
    add(1'b0,1'b0,1'b0,1'b0,1'b1, 32'h0, 32'h0,        1'b1,1'b1,1'b0,3'd2, mk(32'h54,32'hE4,32'h0,32'h0,32'h0));
    add(1'b0,1'b0,1'b0,1'b0,1'b1, 32'h0, 32'h0,        1'b1,1'b1,1'b0,3'd1, mk(32'h55,32'h0,32'h0,32'h0,32'h0));
    add(1'b0,1'b0,1'b0,1'b0,1'b1, 32'h0, 32'h0,        1'b1,1'b0,1'b0,3'd0, z);
    add(1'b0,1'b0,1'b0,1'b0,1'b1, 32'h0, 32'h0,        1'b1,1'b0,1'b0,3'd0, z);
    // two packets queued and a partial message in flight before reset
    add(1'b1,1'b1,1'b0,1'b0,1'b0, 32'h61, 32'h0,       1'b1,1'b1,1'b0,3'd1, mk(32'h61,32'h0,32'h0,32'h0,32'h0));
    add(1'b1,1'b1,1'b0,1'b0,1'b0, 32'h62, 32'h0,       1'b1,1'b1,1'b0,3'd1, mk(32'h61,32'h0,32'h0,32'h0,32'h0));
    add(1'b1,1'b1,1'b0,1'b0,1'b0, 32'h63, 32'h0,       1'b1,1'b1,1'b0,3'd1, mk(32'h61,32'h0,32'h0,32'h0,32'h0));
    add(1'b0,1'b0,1'b0,1'b0,1'b1, 32'h0, 32'h0,        1'b1,1'b1,1'b0,3'd1, mk(32'h62,32'h0,32'h0,32'h0,32'h0));
    add(1'b1,1'b0,1'b0,1'b0,1'b0, 32'h70, 32'h71,      1'b1,1'b1,1'b0,3'd1, mk(32'h62,32'h0,32'h0,32'h0,32'h0));

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset ready", {159'h0, bus_if.ready_o}, 160'h1);
    check("reset req", {159'h0, bus_if.r_msg_to_pkt_o}, 160'h0);
    check("reset ovf", {159'h0, bus_if.overflow_o}, 160'h0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i].cv, vq[i].ho, vq[i].last, vq[i].ab, vq[i].g, vq[i].hdr, vq[i].dat);
      @(posedge clk);
      #1;
      check($sformatf("v%0d ready", i), {159'h0, bus_if.ready_o}, {159'h0, vq[i].e_rdy});
      check($sformatf("v%0d req", i), {159'h0, bus_if.r_msg_to_pkt_o}, {159'h0, vq[i].e_req});
      check($sformatf("v%0d ovf", i), {159'h0, bus_if.overflow_o}, {159'h0, vq[i].e_ovf});
      if (vq[i].e_req) begin
        check($sformatf("v%0d len", i), {157'h0, bus_if.out_len_o}, {157'h0, vq[i].e_len});
        check($sformatf("v%0d link", i), bus_if.out_link_o, vq[i].e_link);
      end
    end

    // Asynchronous reset mid-assembly with two packets queued
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    rst = 1'b1;
    #1;
    check("midrst req", {159'h0, bus_if.r_msg_to_pkt_o}, 160'h0);
    check("midrst ready", {159'h0, bus_if.ready_o}, 160'h1);
    check("midrst ovf", {159'h0, bus_if.overflow_o}, 160'h0);
    @(posedge clk);
    #1;
    check("midrst hold req", {159'h0, bus_if.r_msg_to_pkt_o}, 160'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h80, 32'h81);
    @(posedge clk);
    #1;
    check("postrst req", {159'h0, bus_if.r_msg_to_pkt_o}, 160'h1);
    check("postrst len", {157'h0, bus_if.out_len_o}, 160'h2);
    check("postrst link", bus_if.out_link_o, mk(32'h80, 32'h81, 32'h0, 32'h0, 32'h0));
    check("postrst ready", {159'h0, bus_if.ready_o}, 160'h1);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    check("postrst drained", {159'h0, bus_if.r_msg_to_pkt_o}, 160'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
